fft_frame_ctrl: RTL

FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

---
 rtl/fft_ctrl_pkg.sv | 18 +
 rtl/fft_res_mon.sv | 83 ++++++++
 rtl/fft_frame_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the FFT frame controller: FSM states, default widths and
// the bit layout of the configuration word sent to the FFT core.
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CFG    = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    localparam int unsigned SCALE_W_DEFAULT = 15;

    // Config word is {scale_sch, fwd_inv}.
    localparam int unsigned CFG_FWD_BIT = 0;
    localparam int unsigned CFG_SCH_LSB = 1;

endpackage

// File: rtl/fft_res_mon.sv
// Result-side monitor: counts returned frames and flags misplaced tlast on the core output.
// Optional error counter enabled by FFT_FRAME_CTRL_ERR_CNT_EN.
module fft_res_mon #(
    parameter int unsigned FFT_POINT = 8192,
    parameter int unsigned NF_W      = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            active,
    input  logic            clr,
    input  logic            s_res_tvalid,
    input  logic            s_res_tlast,
    output logic [NF_W-1:0] frames_out,
    output logic            err_last,
    output logic [7:0]      err_cnt
);

    localparam int unsigned CNT_W = $clog2(FFT_POINT);
    localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(FFT_POINT - 1);

    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [NF_W-1:0]  frames_out_q, frames_out_d;
    logic             err_last_q, err_last_d;

    always_comb begin
        beat_cnt_d   = beat_cnt_q;
        frames_out_d = frames_out_q;
        err_last_d   = 1'b0;
        if (s_res_tvalid) begin
            // tlast must coincide exactly with the final beat position.
            err_last_d = s_res_tlast ^ (beat_cnt_q == BEAT_LAST);
            beat_cnt_d = (s_res_tlast || beat_cnt_q == BEAT_LAST) ? '0 : beat_cnt_q + 1'b1;
            if (active && s_res_tlast) begin
                frames_out_d = frames_out_q + NF_W'(1);
            end
        end
        if (clr) begin
            beat_cnt_d   = '0;
            frames_out_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q   <= '0;
            frames_out_q <= '0;
            err_last_q   <= 1'b0;
        end else begin
            beat_cnt_q   <= beat_cnt_d;
            frames_out_q <= frames_out_d;
            err_last_q   <= err_last_d;
        end
    end

    assign frames_out = frames_out_q;
    assign err_last   = err_last_q;

`ifdef FFT_FRAME_CTRL_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr) begin
            err_cnt_d = '0;
        end else if (err_last_d && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame controller feeding an FFT core: config handshake, framed sample streaming,
// result monitoring. Optional error counter via FFT_FRAME_CTRL_ERR_CNT_EN.
module fft_frame_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int unsigned FFT_POINT = 8192,
    parameter int unsigned SCALE_W   = SCALE_W_DEFAULT,
    parameter int unsigned NF_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               fwd_inv,
    input  logic [SCALE_W-1:0] scale_sch,
    input  logic [NF_W-1:0]    nframes,
    input  logic               stop,
    input  logic               i_valid,
    input  logic [13:0]        i_data,
    output logic               i_ready,
    output logic [SCALE_W:0]   m_cfg_tdata,
    output logic               m_cfg_tvalid,
    input  logic               m_cfg_tready,
    output logic [31:0]        m_dat_tdata,
    output logic               m_dat_tvalid,
    output logic               m_dat_tlast,
    input  logic               m_dat_tready,
    input  logic               s_res_tvalid,
    input  logic               s_res_tlast,
    output logic               busy,
    output logic               done,
    output logic               err_last,
    output logic [NF_W-1:0]    frames_in,
    output logic [NF_W-1:0]    frames_out,
    output logic [7:0]         err_cnt
);

    localparam int unsigned CNT_W = $clog2(FFT_POINT);
    localparam logic [CNT_W-1:0] SMP_LAST = CNT_W'(FFT_POINT - 1);

    state_t             state_q, state_d;
    logic               fwd_q, fwd_d;
    logic [SCALE_W-1:0] sch_q, sch_d;
    logic [NF_W-1:0]    nframes_q, nframes_d;
    logic [NF_W-1:0]    acc_frames_q, acc_frames_d;
    logic [NF_W-1:0]    frames_in_q, frames_in_d;
    logic [CNT_W-1:0]   smp_cnt_q, smp_cnt_d;
    logic               stop_req_q, stop_req_d;
    logic [31:0]        dat_q, dat_d;
    logic               dat_valid_q, dat_valid_d;
    logic               dat_last_q, dat_last_d;
    logic               done_q, done_d;

    logic start_acc, slice_free, end_pending, rdy, in_fire;

    always_comb begin
        start_acc  = (state_q == ST_IDLE) && start;
        slice_free = !dat_valid_q || m_dat_tready;
        // A stop only takes effect on a frame boundary; counted runs end after nframes accepted.
        end_pending = ((nframes_q != '0) && (acc_frames_q == nframes_q))
                   || ((stop_req_q || stop) && (smp_cnt_q == '0));
        rdy     = (state_q == ST_STREAM) && !end_pending && slice_free;
        in_fire = i_valid && rdy;
    end

    always_comb begin
        state_d      = state_q;
        fwd_d        = fwd_q;
        sch_d        = sch_q;
        nframes_d    = nframes_q;
        acc_frames_d = acc_frames_q;
        frames_in_d  = frames_in_q;
        smp_cnt_d    = smp_cnt_q;
        stop_req_d   = stop_req_q;
        dat_d        = dat_q;
        dat_valid_d  = dat_valid_q;
        dat_last_d   = dat_last_q;
        done_d       = 1'b0;

        if (in_fire) begin
            dat_d       = {16'h0000, i_data, 2'b00};
            dat_valid_d = 1'b1;
            dat_last_d  = (smp_cnt_q == SMP_LAST);
            smp_cnt_d   = smp_cnt_q + 1'b1;
            if (smp_cnt_q == SMP_LAST) begin
                acc_frames_d = acc_frames_q + NF_W'(1);
            end
        end else if (m_dat_tready) begin
            dat_valid_d = 1'b0;
        end

        if (dat_valid_q && m_dat_tready && dat_last_q) begin
            frames_in_d = frames_in_q + NF_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_CFG;
                    fwd_d        = fwd_inv;
                    sch_d        = scale_sch;
                    nframes_d    = nframes;
                    acc_frames_d = '0;
                    frames_in_d  = '0;
                    smp_cnt_d    = '0;
                    stop_req_d   = 1'b0;
                end
            end
            ST_CFG: begin
                if (stop) stop_req_d = 1'b1;
                if (m_cfg_tready) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (stop) stop_req_d = 1'b1;
                if (end_pending && !dat_valid_q) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (frames_out == frames_in_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            fwd_q        <= 1'b0;
            sch_q        <= '0;
            nframes_q    <= '0;
            acc_frames_q <= '0;
            frames_in_q  <= '0;
            smp_cnt_q    <= '0;
            stop_req_q   <= 1'b0;
            dat_q        <= '0;
            dat_valid_q  <= 1'b0;
            dat_last_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            fwd_q        <= fwd_d;
            sch_q        <= sch_d;
            nframes_q    <= nframes_d;
            acc_frames_q <= acc_frames_d;
            frames_in_q  <= frames_in_d;
            smp_cnt_q    <= smp_cnt_d;
            stop_req_q   <= stop_req_d;
            dat_q        <= dat_d;
            dat_valid_q  <= dat_valid_d;
            dat_last_q   <= dat_last_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        m_cfg_tdata                          = '0;
        m_cfg_tdata[CFG_FWD_BIT]             = fwd_q;
        m_cfg_tdata[CFG_SCH_LSB +: SCALE_W]  = sch_q;
    end

    assign m_cfg_tvalid = (state_q == ST_CFG);
    assign i_ready      = rdy;
    assign m_dat_tdata  = dat_q;
    assign m_dat_tvalid = dat_valid_q;
    assign m_dat_tlast  = dat_last_q;
    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign frames_in    = frames_in_q;

    fft_res_mon #(
        .FFT_POINT (FFT_POINT),
        .NF_W      (NF_W)
    ) u_res_mon (
        .clk          (clk),
        .rst          (rst),
        .active       (busy),
        .clr          (start_acc),
        .s_res_tvalid (s_res_tvalid),
        .s_res_tlast  (s_res_tlast),
        .frames_out   (frames_out),
        .err_last     (err_last),
        .err_cnt      (err_cnt)
    );

endmodule
